// File: rtl/spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spi_slave
//  Description : Byte-oriented SPI target. Oversamples sclk/cs/mosi on clkin,
//                supports all CPOL/CPHA modes and selectable CS polarity,
//                MSB-first 8-bit words, single-entry transmit buffer with a
//                load handshake and a sticky underrun flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave (
    input  logic       clkin,
    input  logic       rst,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       cspol,
    input  logic       sclk,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] data_i,
    input  logic       tx_we,
    output logic       tx_ready,
    output logic       tx_underrun,
    output logic [7:0] data_o,
    output logic       rx_valid,
    output logic       state
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEL  = 1'b1
    } state_t;

    // Synchronizer stages
    logic       r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic       r_cs_s1, r_cs_s2;
    logic       r_mosi_s1, r_mosi_s2;

    // Control / receive path
    state_t     r_state;
    logic       r_sel_prev;
    logic [2:0] r_bitcnt;
    logic [7:0] r_rxsh;
    logic [7:0] r_data_o;
    logic       r_rx_valid;
    logic       r_byte_done;

    // Transmit path
    logic [7:0] r_txsh;
    logic [7:0] r_txbuf;
    logic       r_tx_full;
    logic       r_underrun;

    // Decoded conditions
    logic       w_selected;
    logic       w_lead;
    logic       w_trail;
    logic       w_sample;
    logic       w_shift;
    logic       w_enter;
    logic       w_active;
    logic       w_load;
    logic       w_shift_only;

    // Bring the asynchronous bus pins into the clkin domain; sclk keeps a third stage for edge detection
    always_ff @(posedge clkin) begin
        r_sclk_s1 <= sclk;
        r_sclk_s2 <= r_sclk_s1;
        r_sclk_s3 <= r_sclk_s2;
        r_cs_s1   <= cs;
        r_cs_s2   <= r_cs_s1;
        r_mosi_s1 <= mosi;
        r_mosi_s2 <= r_mosi_s1;
    end

    // cspol is the idle level, so anything else means we are addressed
    assign w_selected = (r_cs_s2 != cspol);

    // Leading edge leaves the idle level, trailing edge returns to it
    assign w_lead   = (r_sclk_s3 == cpol) && (r_sclk_s2 != cpol);
    assign w_trail  = (r_sclk_s3 != cpol) && (r_sclk_s2 == cpol);
    assign w_sample = cpha ? w_trail : w_lead;
    assign w_shift  = cpha ? w_lead  : w_trail;

    // Entry needs a fresh assertion: r_sel_prev comes out of reset set, so a
    // transaction already in progress at reset release is never re-entered.
    assign w_enter  = (r_state == ST_IDLE) && w_selected && !r_sel_prev;
    assign w_active = (r_state == ST_SEL) && w_selected;

    // CPHA=0 presents bit 7 at selection and reloads on the shift edge that
    // closes each byte; CPHA=1 reloads on the first shift edge of each byte.
    assign w_load = (w_enter && !cpha) ||
                    (w_active && w_shift && (cpha ? (r_bitcnt == 3'd0) : r_byte_done));
    assign w_shift_only = w_active && w_shift && !w_load;

    // Select state machine and receive shifter
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sel_prev  <= 1'b1;
            r_bitcnt    <= 3'd0;
            r_rxsh      <= 8'h00;
            r_data_o    <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_byte_done <= 1'b0;
        end else begin
            r_sel_prev <= w_selected;
            r_rx_valid <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (w_enter) begin
                    r_state <= ST_SEL;
                end
            end else if (!w_selected) begin
                // Deselect drops any partial byte
                r_state     <= ST_IDLE;
                r_bitcnt    <= 3'd0;
                r_byte_done <= 1'b0;
            end else begin
                if (w_load) begin
                    r_byte_done <= 1'b0;
                end
                if (w_sample) begin
                    r_rxsh   <= {r_rxsh[6:0], r_mosi_s2};
                    r_bitcnt <= r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        r_data_o    <= {r_rxsh[6:0], r_mosi_s2};
                        r_rx_valid  <= 1'b1;
                        r_byte_done <= 1'b1;
                    end
                end
            end
        end
    end

    // Transmit shifter and single-entry buffer; a load consumes the old
    // buffer contents before a same-cycle write is considered.
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_txsh     <= 8'hFF;
            r_txbuf    <= 8'h00;
            r_tx_full  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_txsh    <= r_tx_full ? r_txbuf : 8'hFF;
                r_tx_full <= 1'b0;
                if (!r_tx_full) begin
                    r_underrun <= 1'b1;
                end
            end else if (w_shift_only) begin
                r_txsh <= {r_txsh[6:0], 1'b0};
            end
            if (tx_we && !r_tx_full) begin
                r_txbuf   <= data_i;
                r_tx_full <= 1'b1;
            end
        end
    end

    assign miso        = r_txsh[7];
    assign state       = (r_state == ST_SEL);
    assign miso_oe     = (r_state == ST_SEL);
    assign tx_ready    = ~r_tx_full;
    assign tx_underrun = r_underrun;
    assign data_o      = r_data_o;
    assign rx_valid    = r_rx_valid;

endmodule
`default_nettype wire
